// File: rtl/multitap_echo.sv
// Multi-tap echo/reverb: circular sample buffer, N decaying taps,
// optional feedback from the longest tap, saturating dry/wet blend.
module multitap_echo #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 11,
    parameter int N_TAPS      = 4,
    parameter int TAP_SPACING = 256,
    parameter int FB_SHIFT    = 1,
    parameter int GAIN_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] audio_in,
    input  logic [GAIN_W-1:0] mix,
    input  logic              fb_en,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] audio_out,
    output logic              overrun
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int AW    = DATA_W + 4;
    localparam int MW    = DATA_W + GAIN_W + 2;
    localparam int FW    = ADDR_W + 1;
    localparam int TW    = 4;

    localparam logic [FW-1:0] FILL_MAX = FW'(N_TAPS * TAP_SPACING);
    localparam logic [TW-1:0] LAST_TAP = TW'(N_TAPS);
    localparam logic signed [MW-1:0] SAT_MAX = MW'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [MW-1:0] SAT_MIN = -SAT_MAX - MW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [DATA_W-1:0]        r_rdata;
    logic [ADDR_W-1:0]        r_wr_ptr;
    logic [FW-1:0]            r_fill;
    logic [TW-1:0]            r_tap;
    logic                     r_rd_vld;
    logic                     r_rd_msk;
    logic [TW-1:0]            r_rd_k;
    logic signed [AW-1:0]     r_acc;
    logic signed [DATA_W-1:0] r_tapn;
    logic signed [DATA_W-1:0] r_dry;
    logic [GAIN_W-1:0]        r_mix;
    logic                     r_fb;
    logic                     r_out_valid;
    logic [DATA_W-1:0]        r_audio_out;
    logic                     r_overrun;

    logic                     w_accept;
    logic                     w_we;
    logic [ADDR_W-1:0]        w_rd_addr;
    logic [FW-1:0]            w_tap_thr;
    logic signed [DATA_W-1:0] w_tap_val;
    logic signed [AW-1:0]     w_tap_ext;
    logic signed [AW-1:0]     w_tap_shr;
    logic signed [MW-1:0]     w_acc_x;
    logic signed [DATA_W-1:0] w_wet;
    logic signed [MW-1:0]     w_dry_x;
    logic signed [MW-1:0]     w_wet_x;
    logic [GAIN_W:0]          w_inv;
    logic signed [MW-1:0]     w_inv_x;
    logic signed [MW-1:0]     w_mix_x;
    logic signed [MW-1:0]     w_sum;
    logic signed [MW-1:0]     w_mixed;
    logic signed [DATA_W-1:0] w_out;
    logic signed [MW-1:0]     w_tapn_x;
    logic signed [MW-1:0]     w_fb_sum;
    logic signed [DATA_W-1:0] w_wr_val;

    function automatic logic signed [DATA_W-1:0] f_sat(
        input logic signed [MW-1:0] x
    );
        if (x > SAT_MAX) return SAT_MAX[DATA_W-1:0];
        if (x < SAT_MIN) return SAT_MIN[DATA_W-1:0];
        return x[DATA_W-1:0];
    endfunction

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_we      = (r_state == S_WRITE);
    assign w_rd_addr = r_wr_ptr - ADDR_W'(r_tap * TAP_SPACING);
    assign w_tap_thr = FW'(r_tap * TAP_SPACING);

    // Taps older than the samples written since reset read as silence
    assign w_tap_val = r_rd_msk ? '0 : $signed(r_rdata);
    assign w_tap_ext = w_tap_val;
    assign w_tap_shr = w_tap_ext >>> r_rd_k;

    assign w_acc_x = r_acc;
    assign w_wet   = f_sat(w_acc_x);
    assign w_dry_x = r_dry;
    assign w_wet_x = w_wet;
    assign w_inv   = (GAIN_W + 1)'(2 ** GAIN_W) - {1'b0, r_mix};
    assign w_inv_x = MW'(w_inv);
    assign w_mix_x = MW'(r_mix);
    assign w_sum   = (w_dry_x * w_inv_x) + (w_wet_x * w_mix_x);
    assign w_mixed = w_sum >>> GAIN_W;
    assign w_out   = f_sat(w_mixed);

    assign w_tapn_x = r_tapn;
    assign w_fb_sum = w_dry_x + (w_tapn_x >>> FB_SHIFT);
    assign w_wr_val = r_fb ? f_sat(w_fb_sum) : r_dry;

    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign audio_out = r_audio_out;
    assign overrun   = r_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid) w_next = S_READ;
            S_READ:  if (r_tap == LAST_TAP) w_next = S_DRAIN;
            S_DRAIN: w_next = S_WRITE;
            S_WRITE: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tap       <= '0;
            r_wr_ptr    <= '0;
            r_fill      <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_msk    <= 1'b0;
            r_rd_k      <= '0;
            r_acc       <= '0;
            r_tapn      <= '0;
            r_dry       <= '0;
            r_mix       <= '0;
            r_fb        <= 1'b0;
            r_out_valid <= 1'b0;
            r_audio_out <= '0;
            r_overrun   <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_rd_vld    <= (r_state == S_READ);
            r_rd_k      <= r_tap;
            r_rd_msk    <= (r_fill < w_tap_thr);
            if (in_valid && (r_state != S_IDLE)) r_overrun <= 1'b1;
            if (w_accept) begin
                r_tap <= TW'(1);
                r_acc <= '0;
                r_dry <= $signed(audio_in);
                r_mix <= mix;
                r_fb  <= fb_en;
            end
            if (r_state == S_READ) r_tap <= r_tap + TW'(1);
            // Read data trails its address by one cycle
            if (r_rd_vld) begin
                r_acc <= r_acc + w_tap_shr;
                if (r_rd_k == LAST_TAP) r_tapn <= w_tap_val;
            end
            if (w_we) begin
                r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
                r_out_valid <= 1'b1;
                r_audio_out <= w_out;
                if (r_fill != FILL_MAX) r_fill <= r_fill + FW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_READ) r_rdata <= r_mem[w_rd_addr];
        if (w_we) r_mem[r_wr_ptr] <= w_wr_val;
    end

endmodule

// File: tb/tb_multitap_echo.sv
// Directed bench for multitap_echo: dry path, impulse, stale RAM,
// saturation, overrun and reset mid-operation.
module tb_multitap_echo;

    localparam int DW = 16;
    localparam int GW = 8;
    localparam int NIMP = 41;

    typedef struct {
        logic signed [DW-1:0] din;
        logic [GW-1:0]        mix;
        logic                 fb;
        logic signed [DW-1:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] audio_in = '0;
    logic [GW-1:0] mix = '0;
    logic          fb_en = 1'b0;
    logic          busy;
    logic          out_valid;
    logic [DW-1:0] audio_out;
    logic          overrun;

    int n_checks = 0;
    int n_fail = 0;

    multitap_echo #(
        .DATA_W(16), .ADDR_W(5), .N_TAPS(4),
        .TAP_SPACING(4), .FB_SHIFT(1), .GAIN_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .audio_in(audio_in), .mix(mix), .fb_en(fb_en),
        .busy(busy), .out_valid(out_valid),
        .audio_out(audio_out), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One strobe; returns output and cycles from accept to out_valid
    task automatic send(input logic signed [DW-1:0] din, input logic [GW-1:0] m,
                        input logic fb, output int got, output int lat);
        in_valid = 1'b1;
        audio_in = din;
        mix = m;
        fb_en = fb;
        @(posedge clk);
        #1 in_valid = 1'b0;
        audio_in = '0;
        lat = -1;
        got = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                got = int'($signed(audio_out));
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t v_dry[3];
    vec_t v_imp[NIMP];
    int   got, lat;
    int   r1[NIMP];
    int   mn, mx, last;
    int   ov_cyc[$];

    initial begin
        v_dry[0] = '{din: 16'sd1000,  mix: 8'd0, fb: 1'b0, exp: 16'sd1000};
        v_dry[1] = '{din: -16'sd2000, mix: 8'd0, fb: 1'b0, exp: -16'sd2000};
        v_dry[2] = '{din: 16'sd32767, mix: 8'd0, fb: 1'b0, exp: 16'sd32767};
        for (int i = 0; i < NIMP; i++) begin
            v_imp[i].din = (i == 0) ? 16'sd16384 : 16'sd0;
            v_imp[i].mix = 8'd128;
            v_imp[i].fb  = 1'b0;
            v_imp[i].exp = 16'sd0;
        end
        v_imp[0].exp  = 16'sd8192;
        v_imp[4].exp  = 16'sd4096;
        v_imp[8].exp  = 16'sd2048;
        v_imp[12].exp = 16'sd1024;
        v_imp[16].exp = 16'sd512;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_audio_out", int'(audio_out), 0);
        chk("rst_overrun", int'(overrun), 0);
        do_reset();

        // Dry path
        for (int i = 0; i < 3; i++) begin
            send(v_dry[i].din, v_dry[i].mix, v_dry[i].fb, got, lat);
            chk($sformatf("dry_out[%0d]", i), got, int'(v_dry[i].exp));
            chk($sformatf("dry_lat[%0d]", i), lat, 6);
            chk($sformatf("dry_ov_pulse[%0d]", i), int'(out_valid), 0);
            chk($sformatf("dry_busy_idle[%0d]", i), int'(busy), 0);
        end

        // Impulse response with wrap
        do_reset();
        for (int i = 0; i < NIMP; i++) begin
            send(v_imp[i].din, v_imp[i].mix, v_imp[i].fb, got, lat);
            r1[i] = got;
            chk($sformatf("imp[%0d]", i), got, int'(v_imp[i].exp));
        end

        // Stale RAM masking
        do_reset();
        for (int i = 0; i < 40; i++) send(16'sd20000, 8'd0, 1'b0, got, lat);
        chk("stale_fill_out", got, 20000);
        do_reset();
        for (int i = 0; i < NIMP; i++) begin
            send(v_imp[i].din, v_imp[i].mix, v_imp[i].fb, got, lat);
            chk($sformatf("stale[%0d]", i), got, int'(v_imp[i].exp));
        end

        // Saturation with feedback
        do_reset();
        mn = 32767;
        mx = -32768;
        last = 0;
        for (int i = 0; i < 64; i++) begin
            send(16'sd32767, 8'd255, 1'b1, got, lat);
            if (got < mn) mn = got;
            if (got > mx) mx = got;
            last = got;
        end
        chk("sat_first_lat", lat, 6);
        chk("sat_min_nonneg", int'(mn >= 0), 1);
        chk("sat_max_le", int'(mx <= 32767), 1);
        // 32767 dry*1 + (16383+8191+4095+2047)*255, >>8
        chk("sat_final", last, 30724);

        // Overrun: in_valid held high
        do_reset();
        audio_in = 16'sd1234;
        mix = 8'd0;
        fb_en = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("ovr_before_drop", int'(overrun), 0);
        for (int c = 1; c <= 36; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) chk("ovr_after_drop", int'(overrun), 1);
            if (out_valid) ov_cyc.push_back(c);
        end
        in_valid = 1'b0;
        chk("ovr_count", ov_cyc.size(), 5);
        for (int i = 0; i < ov_cyc.size(); i++)
            chk($sformatf("ovr_cycle[%0d]", i), ov_cyc[i], 6 + 7 * i);
        chk("ovr_out", int'($signed(audio_out)), 1234);
        chk("ovr_sticky", int'(overrun), 1);

        // Reset mid-operation
        do_reset();
        chk("ovr_cleared", int'(overrun), 0);
        in_valid = 1'b1;
        audio_in = 16'sd16384;
        mix = 8'd128;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("mid_busy", int'(busy), 1);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_overrun", int'(overrun), 0);
        got = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) got++;
        end
        chk("mid_no_out_valid", got, 0);
        send(16'sd16384, 8'd128, 1'b0, got, lat);
        chk("mid_next_out", got, 8192);
        chk("mid_next_lat", lat, 6);
        send(16'sd0, 8'd128, 1'b0, got, lat);
        chk("mid_next_zero", got, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
